// File: rtl/fifo_pop_display.sv
// Pops one FIFO word per button press and shows it on four hex digits; DEBOUNCE_EN adds a press/release debounce.
// Latency: ren 1 cycle after synced press, digits READ_LATENCY+1 cycles after ren; no pop while empty (sets underflow).
module fifo_pop_display #(
  parameter int WIDTH           = 15,
  parameter int READ_LATENCY    = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             button,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdData,
  output logic             ren,
  output logic [6:0]       dataHex0,
  output logic [6:0]       dataHex1,
  output logic [6:0]       dataHex2,
  output logic [6:0]       dataHex3,
  output logic             valid,
  output logic             underflow
);

  typedef enum logic [1:0] {IDLE, LAT, CAPT, WAIT_REL} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [1:0]       btn_sync;
  logic             btn_s, btn_lvl, btn_prev, press;
  logic [1:0]       lat_cnt;
  logic [WIDTH-1:0] held;
  logic             ren_nxt, capture, set_uf;

  // Reset asserts immediately, releases two edges later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) btn_sync <= 2'b11;
    else        btn_sync <= {btn_sync[0], button};
  end
  assign btn_s = btn_sync[1];

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DBW-1:0] db_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      btn_lvl <= 1'b1;
    end else if (btn_s != btn_lvl) begin
      if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        btn_lvl <= btn_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign btn_lvl = btn_s;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) btn_prev <= 1'b1;
    else        btn_prev <= btn_lvl;
  end
  assign press = btn_prev & ~btn_lvl;

  always_comb begin
    state_nxt = state;
    ren_nxt   = 1'b0;
    capture   = 1'b0;
    set_uf    = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          if (empty) begin
            set_uf    = 1'b1;
            state_nxt = WAIT_REL;
          end else begin
            ren_nxt   = 1'b1;
            state_nxt = LAT;
          end
        end
      end
      // ren is high in the first LAT cycle; data is valid READ_LATENCY cycles later.
      LAT: begin
        if (lat_cnt == 2'(READ_LATENCY - 1)) state_nxt = CAPT;
      end
      CAPT: begin
        capture   = 1'b1;
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (btn_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ren       <= 1'b0;
      lat_cnt   <= 2'd0;
      held      <= '0;
      valid     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      ren     <= ren_nxt;
      lat_cnt <= (state == LAT) ? lat_cnt + 2'd1 : 2'd0;
      if (capture) begin
        held      <= rdData;
        valid     <= 1'b1;
        underflow <= 1'b0;
      end else if (set_uf) begin
        underflow <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign dataHex0 = seg7(held[3:0]);
  assign dataHex1 = seg7(held[7:4]);
  assign dataHex2 = seg7(held[11:8]);
  assign dataHex3 = seg7({1'b0, held[14:12]});

endmodule

// File: tb/tb_fifo_pop_display.sv
// Bench for fifo_pop_display: a latency-1 FIFO model feeds the DUT; expectations come from vector tables and a press-level model.
`timescale 1ns/1ps
module tb_fifo_pop_display;
  localparam int DC = 4;
`ifdef DEBOUNCE_EN
  localparam int EXTRA = DC;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LOW_MIN = EXTRA + 1;
  localparam int SETTLE  = 12 + 2 * EXTRA;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        button = 1'b1;
  logic        empty;
  logic [14:0] rdData = 15'h5555;
  logic        ren, valid, underflow;
  logic [6:0]  dataHex0, dataHex1, dataHex2, dataHex3;

  fifo_pop_display #(.WIDTH(15), .READ_LATENCY(1), .DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset_n(reset_n), .button(button), .empty(empty), .rdData(rdData),
    .ren(ren), .dataHex0(dataHex0), .dataHex1(dataHex1), .dataHex2(dataHex2),
    .dataHex3(dataHex3), .valid(valid), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // FIFO model: one word handed out on the edge that ends a ren cycle.
  logic [14:0] store [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign empty = (push_cnt == pop_cnt);
  always @(posedge clock) begin
    if (ren) begin
      rdData  <= store[pop_cnt[7:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  int cyc = 0;
  int ren_total = 0;
  int ren_empty_bad = 0;
  int ren_times[$];
  always @(negedge clock) begin
    cyc++;
    if (ren) begin
      ren_total++;
      ren_times.push_back(cyc);
      if (empty) ren_empty_bad++;
    end
  end

  logic [6:0] glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [14:0] w, input logic v, input logic uf);
    logic [3:0] n3;
    n3 = {1'b0, w[14:12]};
    check({tag, ".hex0"}, 32'(dataHex0), 32'(glyph[w[3:0]]));
    check({tag, ".hex1"}, 32'(dataHex1), 32'(glyph[w[7:4]]));
    check({tag, ".hex2"}, 32'(dataHex2), 32'(glyph[w[11:8]]));
    check({tag, ".hex3"}, 32'(dataHex3), 32'(glyph[n3]));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".underflow"}, 32'(underflow), 32'(uf));
  endtask

  task automatic push(input logic [14:0] d);
    store[push_cnt[7:0]] = d;
    push_cnt++;
  endtask

  task automatic do_press(input int low);
    @(posedge clock); #1 button = 1'b0;
    repeat (low) @(posedge clock);
    #1 button = 1'b1;
    repeat (SETTLE) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        do_push;
    logic [14:0] data;
    int          exp_ren;
    logic        exp_uf;
    logic        exp_valid;
    logic [14:0] exp_word;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int r0, k, min_gap, t0, low;
    bit found, nonempty;
    logic [14:0] m_word, d;
    logic m_valid, m_uf;

    tbl[0] = '{1'b1, 15'h1234, 1, 1'b0, 1'b1, 15'h1234};
    tbl[1] = '{1'b0, 15'h0000, 0, 1'b1, 1'b1, 15'h1234};
    tbl[2] = '{1'b1, 15'h7FFF, 1, 1'b0, 1'b1, 15'h7FFF};
    tbl[3] = '{1'b1, 15'h0ABC, 1, 1'b0, 1'b1, 15'h0ABC};
    tbl[4] = '{1'b0, 15'h0000, 0, 1'b1, 1'b1, 15'h0ABC};
    tbl[5] = '{1'b0, 15'h0000, 0, 1'b1, 1'b1, 15'h0ABC};
    tbl[6] = '{1'b1, 15'h5DEF, 1, 1'b0, 1'b1, 15'h5DEF};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset.ren", 32'(ren), 0);
    check_disp("reset", 15'h0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_push) push(tbl[i].data);
      r0 = ren_total;
      do_press(LOW_MIN + 3);
      check($sformatf("vec%0d.ren_pulses", i), 32'(ren_total - r0), 32'(tbl[i].exp_ren));
      check_disp($sformatf("vec%0d", i), tbl[i].exp_word, tbl[i].exp_valid, tbl[i].exp_uf);
    end

    // Press-to-ren and ren-to-digit timing; empty rises after the pop and must not abort it
    push(15'h0A5C);
    @(posedge clock); #1 button = 1'b0;
    k = 0; found = 0;
    while (!found && k < 20 + EXTRA) begin
      @(negedge clock); k++;
      if (ren) found = 1;
    end
    check("timing.ren_latency", 32'(k), 32'(4 + EXTRA));
    @(negedge clock);
    check("timing.ren_single", 32'(ren), 0);
    check("timing.hex0_before", 32'(dataHex0), 32'(glyph[4'hF]));
    @(negedge clock);
    check("timing.hex0_after", 32'(dataHex0), 32'(glyph[4'hC]));
    check("timing.hex3_after", 32'(dataHex3), 32'(glyph[4'h0]));
    @(posedge clock); #1 button = 1'b1;
    repeat (SETTLE) @(posedge clock);
    #1;

    // Holding the button yields a single pop
    push(15'h1111); push(15'h2222);
    r0 = ren_total;
    do_press(50);
    check("hold.ren_pulses", 32'(ren_total - r0), 1);

    // Eight press/release cycles
    for (int i = 0; i < 7; i++) push(15'(16'h3000 + i));
    r0 = ren_total;
    t0 = ren_times.size();
    for (int i = 0; i < 8; i++) do_press(LOW_MIN + 1);
    check("eight.ren_pulses", 32'(ren_total - r0), 8);
    min_gap = 1000;
    for (int j = t0 + 1; j < ren_times.size(); j++)
      if (ren_times[j] - ren_times[j-1] < min_gap) min_gap = ren_times[j] - ren_times[j-1];
    check("eight.min_gap_ge3", 32'(min_gap >= 3), 1);
    check_disp("eight", 15'h3006, 1'b1, 1'b0);

`ifdef DEBOUNCE_EN
    push(15'h0123);
    r0 = ren_total;
    @(posedge clock); #1 button = 1'b0;
    repeat (DC - 1) @(posedge clock);
    #1 button = 1'b1;
    repeat (SETTLE) @(posedge clock);
    #1;
    check("debounce.glitch_ren", 32'(ren_total - r0), 0);
    do_press(DC);
    check("debounce.press_ren", 32'(ren_total - r0), 1);
    check_disp("debounce", 15'h0123, 1'b1, 1'b0);
`endif

    // Reset during an in-flight pop discards the capture
    push(15'h4321);
    @(posedge clock); #1 button = 1'b0;
    k = 0; found = 0;
    while (!found && k < 20 + EXTRA) begin
      @(negedge clock); k++;
      if (ren) found = 1;
    end
    check("midreset.ren_seen", 32'(found), 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset.ren_now", 32'(ren), 0);
    check_disp("midreset.asserted", 15'h0000, 1'b0, 1'b0);
    @(posedge clock); #1 button = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    r0 = ren_total;
    repeat (SETTLE + 5) @(posedge clock);
    #1;
    check("midreset.no_ren_after", 32'(ren_total - r0), 0);
    check_disp("midreset.released", 15'h0000, 1'b0, 1'b0);

    // Randomized presses against a press-level reference model
    m_word = 15'h0000; m_valid = 1'b0; m_uf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        d = 15'($urandom);
        push(d);
      end
      nonempty = (push_cnt != pop_cnt);
      if (nonempty) begin
        m_word = store[pop_cnt[7:0]];
        m_valid = 1'b1;
        m_uf = 1'b0;
      end else begin
        m_uf = 1'b1;
      end
      low = LOW_MIN + int'($urandom_range(0, 4));
      r0 = ren_total;
      do_press(low);
      check($sformatf("rand%0d.ren_pulses", it), 32'(ren_total - r0), 32'(nonempty));
      check_disp($sformatf("rand%0d", it), m_word, m_valid, m_uf);
    end

    check("ren_while_empty", 32'(ren_empty_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
